// File: rtl/iob_master.sv
// iob_master: I/O bus master sitting downstream of the I/O bridge slave.
// Runs one 68000-style asynchronous bus cycle per accepted request, with
// DTACK, BERR and VPA/E (6800-style) termination plus a wait-state watchdog.
// One CLK period is one 68000 half-state.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   IOREQ, IORW, IOL, IOU          request level, 1=read, byte strobe requests
//   IOACT, IODONE, nBERR_IOB       accepted/in progress, termination pulse,
//                                  0 = last cycle ended in bus error
//   nAS_IOB, nLDS_IOB, nUDS_IOB    address / data strobes
//   nWE_IOB, nVMA_IOB              R/W (1=read), valid memory address
//   nDoutOE, DinLE                 write data drive enable, read latch pulse
//   nDTACK_IOB, nBERRin_IOB,
//   nVPA_IOB, E                    asynchronous bus inputs
module iob_master #(
  parameter int TO_CYCLES = 128,
  parameter int TO_W      = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic IOREQ,
  input  logic IORW,
  input  logic IOL,
  input  logic IOU,
  output logic IOACT,
  output logic IODONE,
  output logic nBERR_IOB,
  output logic nAS_IOB,
  output logic nLDS_IOB,
  output logic nUDS_IOB,
  output logic nWE_IOB,
  output logic nVMA_IOB,
  output logic nDoutOE,
  output logic DinLE,
  input  logic nDTACK_IOB,
  input  logic nBERRin_IOB,
  input  logic nVPA_IOB,
  input  logic E
);

  typedef enum logic [3:0] {
    IDLE, S0, S2, S4, EW, EH, EL, S6, S7, REC
  } state_t;

  state_t            state, state_nx;
  logic              DTr, BEr, VPr, Er;
  logic              rw_r, lds_r, uds_r;
  logic              err_r, vma_r;
  logic              term_err;
  logic              wd_hit;
  logic [TO_W-1:0]   wd_cnt;

  // Input stage: every asynchronous bus input is registered once; the FSM
  // only ever looks at these copies.
  always_ff @(posedge CLK) begin
    DTr <= nDTACK_IOB;
    BEr <= nBERRin_IOB;
    VPr <= nVPA_IOB;
    Er  <= E;
  end

  // Request attributes are held for the whole bus cycle.
  always_ff @(posedge CLK) begin
    if (state == IDLE && IOREQ) begin
      rw_r  <= IORW;
      lds_r <= IOL;
      uds_r <= IOU;
    end
  end

  assign wd_hit = (wd_cnt == TO_W'(TO_CYCLES - 1));

  // FSM state and control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      wd_cnt <= '0;
      err_r  <= 1'b0;
      vma_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && IOREQ) begin
        wd_cnt <= '0;
        err_r  <= 1'b0;
      end else if (state == S4 || state == EW || state == EH || state == EL) begin
        wd_cnt <= wd_cnt + TO_W'(1);
      end
      if (term_err)
        err_r <= 1'b1;
      if (state == EW && state_nx == EH)
        vma_r <= 1'b1;
      else if (state == S6)
        vma_r <= 1'b0;
    end
  end

  // Next-state decode. In S4 a real termination (BERR, then DTACK) beats the
  // watchdog; DTACK and BERR are not looked at once an E-cycle has begun.
  always_comb begin
    state_nx = state;
    term_err = 1'b0;
    case (state)
      IDLE: if (IOREQ) state_nx = S0;
      S0:   state_nx = S2;
      S2:   state_nx = S4;
      S4: begin
        if (!BEr) begin
          state_nx = S6;
          term_err = 1'b1;
        end else if (!DTr) begin
          state_nx = S6;
        end else if (wd_hit) begin
          state_nx = S6;
          term_err = 1'b1;
        end else if (!VPr) begin
          state_nx = EW;
        end
      end
      EW: begin
        if (wd_hit) begin
          state_nx = S6;
          term_err = 1'b1;
        end else if (!Er) begin
          state_nx = EH;
        end
      end
      EH: begin
        if (wd_hit) begin
          state_nx = S6;
          term_err = 1'b1;
        end else if (Er) begin
          state_nx = EL;
        end
      end
      EL: begin
        if (!Er) begin
          state_nx = S6;
        end else if (wd_hit) begin
          state_nx = S6;
          term_err = 1'b1;
        end
      end
      S6:      state_nx = S7;
      S7:      state_nx = REC;
      REC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from registered state only, so IOREQ never reaches an
  // output combinationally. Write strobes wait until S4 so data has settled.
  always_comb begin
    IOACT     = 1'b0;
    IODONE    = 1'b0;
    DinLE     = 1'b0;
    nAS_IOB   = 1'b1;
    nLDS_IOB  = 1'b1;
    nUDS_IOB  = 1'b1;
    nWE_IOB   = 1'b1;
    nDoutOE   = 1'b1;
    nBERR_IOB = ~err_r;
    nVMA_IOB  = ~vma_r;
    case (state)
      S0: begin
        IOACT   = 1'b1;
        nWE_IOB = rw_r;
        nDoutOE = rw_r;
      end
      S2: begin
        IOACT   = 1'b1;
        nWE_IOB = rw_r;
        nDoutOE = rw_r;
        nAS_IOB = 1'b0;
        if (rw_r) begin
          nLDS_IOB = ~lds_r;
          nUDS_IOB = ~uds_r;
        end
      end
      S4, EW, EH, EL, S6: begin
        IOACT    = 1'b1;
        nWE_IOB  = rw_r;
        nDoutOE  = rw_r;
        nAS_IOB  = 1'b0;
        nLDS_IOB = ~lds_r;
        nUDS_IOB = ~uds_r;
        if (state == S6) begin
          IODONE = 1'b1;
          DinLE  = rw_r;
        end
      end
      S7:      IOACT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_master.sv
module tb_iob_master;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IOREQ = 1'b0, IORW = 1'b1, IOL = 1'b0, IOU = 1'b0;
  logic nDTACK_IOB = 1'b1, nBERRin_IOB = 1'b1, nVPA_IOB = 1'b1, E = 1'b0;
  logic IOACT, IODONE, nBERR_IOB, nAS_IOB, nLDS_IOB, nUDS_IOB;
  logic nWE_IOB, nVMA_IOB, nDoutOE, DinLE;

  int vectors = 0;
  int miscompares = 0;

  // Event times, in edges counted from the start of watch(); -1 = never seen.
  int t_act_rise, t_act_fall, t_as, t_lds, t_uds, t_we, t_oe;
  int t_vma, t_vma_rise, t_done, n_done, t_din, n_din;
  int berr_at_done, berr_k1;

  iob_master #(.TO_CYCLES(128), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .IOREQ(IOREQ), .IORW(IORW), .IOL(IOL), .IOU(IOU),
    .IOACT(IOACT), .IODONE(IODONE), .nBERR_IOB(nBERR_IOB),
    .nAS_IOB(nAS_IOB), .nLDS_IOB(nLDS_IOB), .nUDS_IOB(nUDS_IOB),
    .nWE_IOB(nWE_IOB), .nVMA_IOB(nVMA_IOB), .nDoutOE(nDoutOE), .DinLE(DinLE),
    .nDTACK_IOB(nDTACK_IOB), .nBERRin_IOB(nBERRin_IOB),
    .nVPA_IOB(nVPA_IOB), .E(E)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected to have finished");
    $fatal(1);
  end

  function automatic logic [9:0] outs();
    return {IOACT, IODONE, DinLE, nBERR_IOB, nAS_IOB, nLDS_IOB, nUDS_IOB,
            nVMA_IOB, nWE_IOB, nDoutOE};
  endfunction

  // E at one tenth of CLK: high for 4 of every 10 cycles.
  function automatic logic e_wave(input int k);
    return ((k % 10) >= 2) && ((k % 10) <= 5);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic restore();
    IOREQ = 1'b0;
    nDTACK_IOB = 1'b1;
    nBERRin_IOB = 1'b1;
    nVPA_IOB = 1'b1;
    E = 1'b0;
    idle(3);
  endtask

  // Runs one bus cycle (IOREQ already high) and records when things happen.
  task automatic watch(input int budget, input int dtack_at, input logic e_run);
    int k;
    bit fin;
    t_act_rise = -1; t_act_fall = -1; t_as = -1; t_lds = -1; t_uds = -1;
    t_we = -1; t_oe = -1; t_vma = -1; t_vma_rise = -1; t_done = -1;
    n_done = 0; t_din = -1; n_din = 0; berr_at_done = -1; berr_k1 = -1;
    k = 0;
    fin = 1'b0;
    while (!fin && k < budget) begin
      @(posedge CLK);
      #1;
      k++;
      if (k == 1) berr_k1 = int'(nBERR_IOB);
      if (IOACT && t_act_rise < 0) t_act_rise = k;
      if (!nAS_IOB && t_as < 0) t_as = k;
      if (!nLDS_IOB && t_lds < 0) t_lds = k;
      if (!nUDS_IOB && t_uds < 0) t_uds = k;
      if (!nWE_IOB && t_we < 0) t_we = k;
      if (!nDoutOE && t_oe < 0) t_oe = k;
      if (!nVMA_IOB && t_vma < 0) t_vma = k;
      if (nVMA_IOB && t_vma >= 0 && t_vma_rise < 0) t_vma_rise = k;
      if (IODONE) begin
        n_done++;
        t_done = k;
        berr_at_done = int'(nBERR_IOB);
      end
      if (DinLE) begin
        n_din++;
        t_din = k;
      end
      if (!IOACT && t_act_rise >= 0) begin
        t_act_fall = k;
        fin = 1'b1;
      end
      if (IOACT) IOREQ = 1'b0;
      if (dtack_at >= 0 && k >= dtack_at) nDTACK_IOB = 1'b0;
      if (e_run) E = e_wave(k);
    end
    if (!fin) begin
      vectors++;
      miscompares++;
      $display("FAIL watch_timeout: IOACT cycle unfinished after %0d cycles, expected completion", budget);
    end
  endtask

  task automatic test_reset();
    logic [9:0] o;
    RST = 1'b1;
    IOREQ = 1'b1;
    idle(3);
    o = outs();
    vectors++;
    if (o !== 10'b0001111111) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected %b", o, 10'b0001111111);
    end
    IOREQ = 1'b0;
    RST = 1'b0;
    idle(2);
    o = outs();
    vectors++;
    if (o !== 10'b0001111111) begin
      miscompares++;
      $display("FAIL idle_outputs: got %b, expected %b", o, 10'b0001111111);
    end
  endtask

  task automatic test_zero_wait_read();
    int got[12];
    int exp[12];
    string nm[12];
    IORW = 1'b1; IOL = 1'b1; IOU = 1'b1;
    nDTACK_IOB = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    watch(20, 0, 1'b0);
    got = '{t_act_rise, t_as, t_lds, t_uds, t_we, t_oe, t_done, n_done,
            t_din, n_din, berr_at_done, t_act_fall};
    exp = '{1, 2, 2, 2, -1, -1, 4, 1, 4, 1, 1, 6};
    nm  = '{"act_rise", "as_fall", "lds_fall", "uds_fall", "we_fall", "oe_fall",
            "done_at", "done_cnt", "dinle_at", "dinle_cnt", "berr_at_done", "act_fall"};
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL zero_wait_read.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
    restore();
  endtask

  task automatic test_write_wait();
    int got[11];
    int exp[11];
    string nm[11];
    IORW = 1'b0; IOL = 1'b1; IOU = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    watch(30, 5, 1'b0);
    got = '{t_act_rise, t_we, t_oe, t_as, t_lds, t_uds, t_done, n_done,
            n_din, berr_at_done, t_act_fall};
    exp = '{1, 1, 1, 2, 3, -1, 7, 1, 0, 1, 9};
    nm  = '{"act_rise", "we_fall", "oe_fall", "as_fall", "lds_fall", "uds_fall",
            "done_at", "done_cnt", "dinle_cnt", "berr_at_done", "act_fall"};
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL write_wait.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
    restore();
  endtask

  task automatic test_no_strobes();
    int got[5];
    int exp[5];
    string nm[5];
    IORW = 1'b1; IOL = 1'b0; IOU = 1'b0;
    nDTACK_IOB = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    watch(20, 0, 1'b0);
    got = '{t_as, t_lds, t_uds, t_done, t_act_fall};
    exp = '{2, -1, -1, 4, 6};
    nm  = '{"as_fall", "lds_fall", "uds_fall", "done_at", "act_fall"};
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL no_strobes.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
    restore();
  endtask

  task automatic test_berr_and_dtack();
    int got[6];
    int exp[6];
    string nm[6];
    IORW = 1'b1; IOL = 1'b1; IOU = 1'b1;
    nDTACK_IOB = 1'b0;
    nBERRin_IOB = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    watch(20, 0, 1'b0);
    restore();
    got = '{t_done, berr_at_done, t_din, n_din, t_act_fall, int'(nBERR_IOB)};
    exp = '{4, 0, 4, 1, 6, 0};
    nm  = '{"done_at", "berr_at_done", "dinle_at", "dinle_cnt", "act_fall", "berr_held"};
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL berr_dtack.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
  endtask

  task automatic test_vpa_cycle();
    int got[9];
    int exp[9];
    string nm[9];
    IORW = 1'b1; IOL = 1'b1; IOU = 1'b1;
    nVPA_IOB = 1'b0;
    E = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    // DTACK goes low mid E-cycle and must be ignored.
    watch(40, 9, 1'b1);
    got = '{berr_k1, t_as, t_vma, t_vma_rise, t_done, n_done, t_din,
            berr_at_done, t_act_fall};
    exp = '{1, 2, 8, 19, 18, 1, 18, 1, 20};
    nm  = '{"berr_cleared", "as_fall", "vma_fall", "vma_rise", "done_at",
            "done_cnt", "dinle_at", "berr_at_done", "act_fall"};
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL vpa_cycle.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
    restore();
  endtask

  task automatic test_timeout();
    int got[5];
    int exp[5];
    string nm[5];
    IORW = 1'b1; IOL = 1'b1; IOU = 1'b1;
    idle(2);
    IOREQ = 1'b1;
    watch(200, -1, 1'b0);
    got = '{t_done, berr_at_done, t_din, n_din, t_act_fall};
    exp = '{131, 0, 131, 1, 133};
    nm  = '{"done_at", "berr_at_done", "dinle_at", "dinle_cnt", "act_fall"};
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL timeout.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
    restore();
  endtask

  task automatic test_reset_in_eh_back_to_back();
    int got[8];
    int exp[8];
    string nm[8];
    int k1_berr, vma_eh, snap, rise2, done2, fall2, act17, rise3;
    logic prev;
    IORW = 1'b1; IOL = 1'b1; IOU = 1'b1;
    nVPA_IOB = 1'b0;
    E = 1'b0;
    idle(2);
    IOREQ = 1'b1;
    k1_berr = -1; vma_eh = -1; snap = -1;
    rise2 = -1; done2 = -1; fall2 = -1; act17 = -1; rise3 = -1;
    prev = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge CLK);
      #1;
      if (k == 1) k1_berr = int'(nBERR_IOB);
      if (k == 9) vma_eh = int'(nVMA_IOB);
      if (k == 10) snap = int'(outs());
      if (k == 17) act17 = int'(IOACT);
      if (k > 10) begin
        if (IOACT && !prev && rise2 < 0) rise2 = k;
        else if (IOACT && !prev && rise3 < 0) rise3 = k;
        if (!IOACT && prev && rise2 >= 0 && fall2 < 0) fall2 = k;
        if (IODONE && done2 < 0) done2 = k;
      end
      prev = IOACT;
      if (k < 9) E = e_wave(k);
      if (k == 9) RST = 1'b1;
      if (k == 10) begin
        RST = 1'b0;
        nVPA_IOB = 1'b1;
        nDTACK_IOB = 1'b0;
        E = 1'b0;
      end
      if (k >= 19) IOREQ = 1'b0;
    end
    restore();
    idle(6);
    got = '{k1_berr, vma_eh, snap, rise2, done2, fall2, act17, rise3};
    exp = '{1, 0, int'(10'b0001111111), 11, 14, 16, 0, 18};
    nm  = '{"berr_cleared", "vma_in_eh", "reset_snapshot", "act_rise2",
            "done2_at", "act_fall2", "act_in_idle", "act_rise3"};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL reset_eh.%s: got %0d, expected %0d", nm[i], got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_no_strobes();
    test_berr_and_dtack();
    test_vpa_cycle();
    test_timeout();
    test_reset_in_eh_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
